// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: DEPTH x WIDTH register file, 1 write / 2 registered reads,
// write-to-read bypass, range guard, sequential clear FSM. Option: REGFILE_PARITY_EN.
module regfile_2r1w_clr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  input  logic             clr_req,
`ifdef REGFILE_PARITY_EN
  input  logic             pinj,
`endif
  output logic             busy,
  output logic             clr_done,
  output logic             rd_perr_a,
  output logic             rd_perr_b
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             clearing;
  logic             wr_ok;
  logic             ok_a, ok_b;
  logic             byp_a, byp_b;
  logic [WIDTH-1:0] nxt_a, nxt_b;

  assign clearing = (state == CLEAR);
  assign wr_ok    = wr_en && !clearing && ({1'b0, wr_addr} < DEPTH_W);
  assign ok_a     = ({1'b0, rd_addr_a} < DEPTH_W);
  assign ok_b     = ({1'b0, rd_addr_b} < DEPTH_W);
  assign byp_a    = wr_ok && (rd_addr_a == wr_addr);
  assign byp_b    = wr_ok && (rd_addr_b == wr_addr);

  // Read data selection: a clearing file reads as zero, bypass beats storage.
  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    if (!clearing && ok_a) nxt_a = byp_a ? wr_data : mem[rd_addr_a];
    if (!clearing && ok_b) nxt_b = byp_b ? wr_data : mem[rd_addr_b];
  end

  // Storage: reset and clear zero words, otherwise the guarded write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clearing) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Clear sequencer: IDLE -> CLEAR (DEPTH cycles) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Port A: one-cycle read pipeline, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else begin
      rd_valid_a <= rd_en_a;
      if (rd_en_a) rd_data_a <= nxt_a;
    end
  end

  // Port B: one-cycle read pipeline, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_b <= rd_en_b;
      if (rd_en_b) rd_data_b <= nxt_b;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par [DEPTH];
  logic perr_a_n, perr_b_n;

  assign perr_a_n = ok_a && !byp_a && !clearing &&
                    (par[rd_addr_a] != ^mem[rd_addr_a]);
  assign perr_b_n = ok_b && !byp_b && !clearing &&
                    (par[rd_addr_b] != ^mem[rd_addr_b]);

  // Parity storage follows the data writes; pinj corrupts it for test.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
    end else if (clearing) begin
      par[ptr] <= 1'b0;
    end else if (wr_ok) begin
      par[wr_addr] <= (^wr_data) ^ pinj;
    end
  end

  // Parity error flags pulse alongside rd_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_perr_a <= 1'b0;
      rd_perr_b <= 1'b0;
    end else begin
      rd_perr_a <= rd_en_a && perr_a_n;
      rd_perr_b <= rd_en_b && perr_b_n;
    end
  end
`else
  assign rd_perr_a = 1'b0;
  assign rd_perr_b = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb_regfile_2r1w_clr: scoreboard bench for regfile_2r1w_clr (DEPTH=8 and DEPTH=6).
// Build with +define+REGFILE_PARITY_EN to also exercise parity.
module tb_regfile_2r1w_clr;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       wr_en, rd_en_a, rd_en_b, clr_req;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b, busy, clr_done, rd_perr_a, rd_perr_b;

  logic       wr_en6, rd_en_a6, rd_en_b6;
  logic [2:0] wr_addr6, rd_addr_a6, rd_addr_b6;
  logic [7:0] wr_data6, rd_data_a6, rd_data_b6;
  logic       rd_valid_a6, rd_valid_b6, busy6, clr_done6;
  logic       rd_perr_a6, rd_perr_b6;
`ifdef REGFILE_PARITY_EN
  logic       pinj;
`endif

  exp_t qa[$], qb[$], qa6[$], qb6[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_2r1w_clr #(.WIDTH(8), .DEPTH(8), .AW(3)) u_dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .clr_req(clr_req),
`ifdef REGFILE_PARITY_EN
    .pinj(pinj),
`endif
    .busy(busy), .clr_done(clr_done),
    .rd_perr_a(rd_perr_a), .rd_perr_b(rd_perr_b)
  );

  regfile_2r1w_clr #(.WIDTH(8), .DEPTH(6), .AW(3)) u_dut6 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
    .rd_en_a(rd_en_a6), .rd_addr_a(rd_addr_a6),
    .rd_data_a(rd_data_a6), .rd_valid_a(rd_valid_a6),
    .rd_en_b(rd_en_b6), .rd_addr_b(rd_addr_b6),
    .rd_data_b(rd_data_b6), .rd_valid_b(rd_valid_b6),
    .clr_req(1'b0),
`ifdef REGFILE_PARITY_EN
    .pinj(1'b0),
`endif
    .busy(busy6), .clr_done(clr_done6),
    .rd_perr_a(rd_perr_a6), .rd_perr_b(rd_perr_b6)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic v, input logic [7:0] d,
                         input logic p, inout exp_t q[$]);
    exp_t e;
    if (!v) return;
    if (q.size() == 0) begin
      chk({name, "_unexpected_valid"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({name, "_data"}, {24'd0, d}, {24'd0, e.data});
    chk({name, "_perr"}, {31'd0, p}, {31'd0, e.perr});
    chk({name, "_latency"}, cyc, e.cyc + 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 0; rd_en_a = 0; rd_en_b = 0;
    wr_en6 = 0; rd_en_a6 = 0; rd_en_b6 = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic rda(input logic [2:0] a, input logic [7:0] d,
                     input logic p = 1'b0);
    exp_t e;
    rd_en_a = 1; rd_addr_a = a;
    e.data = d; e.perr = p; e.cyc = cyc;
    qa.push_back(e);
  endtask

  task automatic rdb(input logic [2:0] a, input logic [7:0] d,
                     input logic p = 1'b0);
    exp_t e;
    rd_en_b = 1; rd_addr_b = a;
    e.data = d; e.perr = p; e.cyc = cyc;
    qb.push_back(e);
  endtask

  task automatic w6(input logic [2:0] a, input logic [7:0] d);
    wr_en6 = 1; wr_addr6 = a; wr_data6 = d;
  endtask

  task automatic ra6(input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    rd_en_a6 = 1; rd_addr_a6 = a;
    e.data = d; e.perr = 0; e.cyc = cyc;
    qa6.push_back(e);
  endtask

  task automatic rb6(input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    rd_en_b6 = 1; rd_addr_b6 = a;
    e.data = d; e.perr = 0; e.cyc = cyc;
    qb6.push_back(e);
  endtask

  // Counts busy cycles until clr_done; optional mid-clear write/read.
  task automatic run_clear(input bit poke, output int n, output bit seen);
    n = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (clr_done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      if (poke && k == 3) begin
        wr(3'd2, 8'h99);
        rda(3'd4, 8'h00);
      end
      step();
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    int  dn;

    reset = 1; clr_req = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
    wr_en6 = 0; wr_addr6 = 0; wr_data6 = 0;
    rd_en_a6 = 0; rd_addr_a6 = 0; rd_en_b6 = 0; rd_addr_b6 = 0;
`ifdef REGFILE_PARITY_EN
    pinj = 0;
`endif

    fork
      forever begin
        @(negedge clk);
        pop_chk("rd_a", rd_valid_a, rd_data_a, rd_perr_a, qa);
        pop_chk("rd_b", rd_valid_b, rd_data_b, rd_perr_b, qb);
        pop_chk("rd_a6", rd_valid_a6, rd_data_a6, rd_perr_a6, qa6);
        pop_chk("rd_b6", rd_valid_b6, rd_data_b6, rd_perr_b6, qb6);
      end
    join_none

    step(); step();
    reset = 0;
    chk("rst_data_a", {24'd0, rd_data_a}, 0);
    chk("rst_data_b", {24'd0, rd_data_b}, 0);
    chk("rst_valid_a", {31'd0, rd_valid_a}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, clr_done}, 0);
    chk("rst_perr_a", {31'd0, rd_perr_a}, 0);
    rda(3'd0, 8'h00); rdb(3'd7, 8'h00); step();

    wr(3'd3, 8'hA5); step();
    rda(3'd3, 8'hA5); step();

    wr(3'd5, 8'h3C); rda(3'd5, 8'h3C); rdb(3'd5, 8'h3C); step();
    rda(3'd5, 8'h3C); step();
    step();
    chk("hold_data_a", {24'd0, rd_data_a}, 32'h3C);
    chk("hold_valid_a", {31'd0, rd_valid_a}, 0);
    wr(3'd5, 8'h5A); rdb(3'd3, 8'hA5); rda(3'd5, 8'h5A); step();
    rdb(3'd5, 8'h5A); step();

    for (int i = 0; i < 6; i++) begin
      w6(3'(i), 8'h20 + 8'(i)); step();
    end
    w6(3'd7, 8'hFF); step();
    ra6(3'd7, 8'h00); rb6(3'd6, 8'h00); step();
    w6(3'd7, 8'hEE); ra6(3'd7, 8'h00); step();
    for (int i = 0; i < 6; i++) begin
      ra6(3'(i), 8'h20 + 8'(i)); rb6(3'(5 - i), 8'h25 - 8'(i)); step();
    end

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'h11 * 8'(i + 1)); step();
    end
    rda(3'd7, 8'h88); rdb(3'd0, 8'h11); step();
    clr_req = 1; step();
    run_clear(1'b1, n, seen);
    chk("clr_busy_cycles", n, 8);
    chk("clr_done_seen", {31'd0, seen}, 1);
    chk("clr_done_busy_low", {31'd0, busy}, 0);
    step();
    clr_req = 0;
    chk("clr_done_one_cycle", {31'd0, clr_done}, 0);
    step();
    chk("clr_no_retrigger", {31'd0, busy}, 0);
    for (int i = 0; i < 8; i++) begin
      rda(3'(i), 8'h00); rdb(3'(7 - i), 8'h00); step();
    end

    wr(3'd1, 8'h42); step();
    rda(3'd1, 8'h42); step();
    clr_req = 1; step();
    clr_req = 0; step(); step();
    reset = 1; step();
    reset = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, clr_done}, 0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (clr_done || busy) dn++;
      step();
    end
    chk("abort_idle", dn, 0);
    rda(3'd1, 8'h00); rdb(3'd7, 8'h00); step();
    wr(3'd6, 8'h66); step();
    clr_req = 1; step();
    clr_req = 0;
    run_clear(1'b0, n, seen);
    chk("restart_busy_cycles", n, 8);
    chk("restart_done_seen", {31'd0, seen}, 1);
    step();
    rda(3'd6, 8'h00); step();

`ifdef REGFILE_PARITY_EN
    pinj = 1; wr(3'd6, 8'h07); step();
    pinj = 0; rda(3'd6, 8'h07, 1'b1); step();
    wr(3'd6, 8'h07); step();
    rda(3'd6, 8'h07, 1'b0); step();
    pinj = 1; wr(3'd4, 8'h07); rda(3'd4, 8'h07, 1'b0); step();
    pinj = 0; rdb(3'd4, 8'h07, 1'b1); step();
`endif

    step(); step();
    chk("drain_qa", qa.size(), 0);
    chk("drain_qb", qb.size(), 0);
    chk("drain_qa6", qa6.size(), 0);
    chk("drain_qb6", qb6.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
